// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// branch_resolve_unit_pkg: shared constants and types for branch resolution.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

   localparam logic [2:0] COND_NE     = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GE     = 3'b100;
   localparam logic [2:0] COND_LE     = 3'b101;
   localparam logic [2:0] COND_OV     = 3'b110;
   localparam logic [2:0] COND_ALWAYS = 3'b111;

   localparam int FLAG_Z = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 2;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE     = 1'b0;
   localparam state_t ST_REDIRECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// branch_cond_eval: same-cycle flag bypass and condition-code decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
   import branch_resolve_unit_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   input  logic [2:0] ex_flag_wen,
   input  logic [2:0] ex_flags,
   output logic       taken
);

   logic [2:0] w_eff;
   logic       w_z;
   logic       w_v;
   logic       w_n;

   // A flag being written this cycle overrides the stale register value bit by bit.
   assign w_eff = (ex_flag_wen & ex_flags) | (~ex_flag_wen & flags);
   assign w_z   = w_eff[FLAG_Z];
   assign w_v   = w_eff[FLAG_V];
   assign w_n   = w_eff[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_NE:     taken = ~w_z;
         COND_EQ:     taken = w_z;
         COND_GT:     taken = ~w_z & ~w_n;
         COND_LT:     taken = w_n;
         COND_GE:     taken = w_z | (~w_z & ~w_n);
         COND_LE:     taken = w_n | w_z;
         COND_OV:     taken = w_v;
         COND_ALWAYS: taken = 1'b1;
         default:     taken = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit: resolves B/BR branches, issues held redirect + flush,
// and keeps saturating taken/not-taken statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int IMM_W  = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic              br_is_reg,
   input  logic [2:0]        cond,
   input  logic [ADDR_W-1:0] pc_plus2,
   input  logic [IMM_W-1:0]  imm,
   input  logic [ADDR_W-1:0] reg_target,
   input  logic [2:0]        flags,
   input  logic [2:0]        ex_flag_wen,
   input  logic [2:0]        ex_flags,
   output logic              redirect_valid,
   input  logic              redirect_ready,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              flush,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  nottaken_cnt
);

   state_t            r_state;
   logic              r_redirect_valid;
   logic [ADDR_W-1:0] r_redirect_pc;
   logic              r_flush;
   logic [CNT_W-1:0]  r_taken_cnt;
   logic [CNT_W-1:0]  r_nottaken_cnt;

   logic              w_taken;
   logic              w_accept;
   logic [ADDR_W-1:0] w_imm_ext;
   logic [ADDR_W-1:0] w_offset;
   logic [ADDR_W-1:0] w_target;

   branch_cond_eval u_cond_eval (
      .cond        (cond),
      .flags       (flags),
      .ex_flag_wen (ex_flag_wen),
      .ex_flags    (ex_flags),
      .taken       (w_taken)
   );

   assign br_ready = (r_state == ST_IDLE);
   assign w_accept = br_valid & br_ready;

   // Word offset: sign-extend then scale to bytes; the add wraps modulo 2^ADDR_W.
   assign w_imm_ext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign w_offset  = {w_imm_ext[ADDR_W-2:0], 1'b0};
   assign w_target  = br_is_reg ? reg_target : (pc_plus2 + w_offset);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_taken_cnt      <= '0;
         r_nottaken_cnt   <= '0;
      end else begin
         r_flush <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_taken) begin
                     r_state          <= ST_REDIRECT;
                     r_redirect_valid <= 1'b1;
                     r_redirect_pc    <= w_target;
                     r_flush          <= 1'b1;
                     if (r_taken_cnt != {CNT_W{1'b1}})
                        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                  end else begin
                     if (r_nottaken_cnt != {CNT_W{1'b1}})
                        r_nottaken_cnt <= r_nottaken_cnt + CNT_W'(1);
                  end
               end
            end
            ST_REDIRECT: begin
               // Target and valid stay frozen until fetch takes the redirect.
               if (redirect_ready) begin
                  r_state          <= ST_IDLE;
                  r_redirect_valid <= 1'b0;
               end
            end
            default: begin
               r_state          <= ST_IDLE;
               r_redirect_valid <= 1'b0;
            end
         endcase
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign flush          = r_flush;
   assign taken_cnt      = r_taken_cnt;
   assign nottaken_cnt   = r_nottaken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit: self-checking bench against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

   localparam int ADDR_W = 16;
   localparam int IMM_W  = 9;
   localparam int CNT_W  = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst_n;
   logic              br_valid;
   logic              br_ready;
   logic              br_is_reg;
   logic [2:0]        cond;
   logic [ADDR_W-1:0] pc_plus2;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] reg_target;
   logic [2:0]        flags;
   logic [2:0]        ex_flag_wen;
   logic [2:0]        ex_flags;
   logic              redirect_valid;
   logic              redirect_ready;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;
   logic [CNT_W-1:0]  taken_cnt;
   logic [CNT_W-1:0]  nottaken_cnt;

   int checks   = 0;
   int failures = 0;
   int m_taken    = 0;
   int m_nottaken = 0;

   branch_resolve_unit #(
      .ADDR_W (ADDR_W),
      .IMM_W  (IMM_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_is_reg      (br_is_reg),
      .cond           (cond),
      .pc_plus2       (pc_plus2),
      .imm            (imm),
      .reg_target     (reg_target),
      .flags          (flags),
      .ex_flag_wen    (ex_flag_wen),
      .ex_flags       (ex_flags),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .taken_cnt      (taken_cnt),
      .nottaken_cnt   (nottaken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition truth from the architectural rules on the effective flags.
   function automatic bit ref_taken(int c, int f, int wen, int exf);
      int eff, z, v, n;
      eff = (wen & exf) | (~wen & f);
      z = eff & 1;
      v = (eff >> 1) & 1;
      n = (eff >> 2) & 1;
      case (c)
         0: return z == 0;
         1: return z == 1;
         2: return (z == 0) && (n == 0);
         3: return n == 1;
         4: return (z == 1) || (n == 0);
         5: return (n == 1) || (z == 1);
         6: return v == 1;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int ref_target(bit is_reg, int pc, int im, int rt);
      int off;
      if (is_reg) return rt;
      off = (im >= 256) ? im - 512 : im;
      return (pc + 2 * off) & 16'hFFFF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit is_reg, int c, int pc, int im, int rt, int f, int wen, int exf);
      br_is_reg   = is_reg;
      cond        = c[2:0];
      pc_plus2    = pc[ADDR_W-1:0];
      imm         = im[IMM_W-1:0];
      reg_target  = rt[ADDR_W-1:0];
      flags       = f[2:0];
      ex_flag_wen = wen[2:0];
      ex_flags    = exf[2:0];
   endtask

   task automatic model_count(bit tk);
      if (tk) begin
         if (m_taken < CNT_MAX) m_taken++;
      end else begin
         if (m_nottaken < CNT_MAX) m_nottaken++;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      br_valid = 1'b0;
      redirect_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      m_taken = 0;
      m_nottaken = 0;
      tick();
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      apply_reset();
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b flush=%b pc=%h want 0 0 0000", redirect_valid, flush, redirect_pc);
      end
      checks++;
      if (taken_cnt !== 16'h0 || nottaken_cnt !== 16'h0 || br_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_counters: got taken=%h nottaken=%h ready=%b want 0 0 1", taken_cnt, nottaken_cnt, br_ready);
      end
   endtask

   task automatic test_eq_basic();
      drive(0, 1, 16'h0010, 9'h1FE, 0, 3'b001, 0, 0);
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      model_count(1);
      checks++;
      if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 16'h000C) begin
         failures++;
         $display("FAIL eq_basic: got valid=%b flush=%b pc=%h want 1 1 000c", redirect_valid, flush, redirect_pc);
      end
      checks++;
      if (taken_cnt !== 16'd1 || br_ready !== 1'b0) begin
         failures++;
         $display("FAIL eq_basic_cnt: got taken=%0d ready=%b want 1 0", taken_cnt, br_ready);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1) begin
         failures++;
         $display("FAIL eq_release: got valid=%b flush=%b ready=%b want 0 0 1", redirect_valid, flush, br_ready);
      end
   endtask

   task automatic test_bypass();
      drive(0, 0, 16'h0100, 9'h004, 0, 3'b000, 3'b001, 3'b001);
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      model_count(0);
      checks++;
      if (redirect_valid !== 1'b0 || nottaken_cnt !== m_nottaken[CNT_W-1:0] || br_ready !== 1'b1) begin
         failures++;
         $display("FAIL bypass_ne: got valid=%b nottaken=%0d ready=%b want 0 %0d 1", redirect_valid, nottaken_cnt, br_ready, m_nottaken);
      end
      drive(0, 1, 16'h0100, 9'h004, 0, 3'b000, 3'b001, 3'b001);
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      model_count(1);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0108 || taken_cnt !== m_taken[CNT_W-1:0]) begin
         failures++;
         $display("FAIL bypass_eq: got valid=%b pc=%h taken=%0d want 1 0108 %0d", redirect_valid, redirect_pc, taken_cnt, m_taken);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      drive(1, 7, 16'h0200, 0, 16'hBEEF, 0, 0, 0);
      br_valid = 1'b1;
      tick();
      model_count(1);
      // A second (not-taken) branch stays presented while the redirect is stalled.
      drive(0, 0, 16'h0300, 0, 0, 3'b001, 0, 0);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 16'hBEEF || br_ready !== 1'b0 || flush !== (cyc == 1)) begin
            failures++;
            $display("FAIL backpressure_c%0d: got valid=%b pc=%h ready=%b flush=%b want 1 beef 0 %b", cyc, redirect_valid, redirect_pc, br_ready, flush, cyc == 1);
         end
         if (cyc == 4) redirect_ready = 1'b1;
         tick();
      end
      br_valid = 1'b0;
      redirect_ready = 1'b0;
      checks++;
      if (redirect_valid !== 1'b0 || taken_cnt !== m_taken[CNT_W-1:0] || nottaken_cnt !== m_nottaken[CNT_W-1:0]) begin
         failures++;
         $display("FAIL backpressure_end: got valid=%b taken=%0d nottaken=%0d want 0 %0d %0d", redirect_valid, taken_cnt, nottaken_cnt, m_taken, m_nottaken);
      end
   endtask

   task automatic test_wrap();
      drive(0, 7, 16'hFFFE, 9'h002, 0, 0, 0, 0);
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      model_count(1);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0002) begin
         failures++;
         $display("FAIL wrap: got valid=%b pc=%h want 1 0002", redirect_valid, redirect_pc);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
   endtask

   task automatic test_cond_sweep();
      bit exp;
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            exp = ref_taken(c, f, 0, 0);
            drive(0, c, 16'h1000, 9'h010, 0, f, 0, 0);
            br_valid = 1'b1;
            tick();
            br_valid = 1'b0;
            model_count(exp);
            checks++;
            if (redirect_valid !== exp || flush !== exp) begin
               failures++;
               $display("FAIL sweep_c%0d_f%0d: got valid=%b flush=%b want %b", c, f, redirect_valid, flush, exp);
            end
            if (exp) begin
               redirect_ready = 1'b1;
               tick();
               redirect_ready = 1'b0;
            end
         end
      end
      checks++;
      if (taken_cnt !== m_taken[CNT_W-1:0] || nottaken_cnt !== m_nottaken[CNT_W-1:0]) begin
         failures++;
         $display("FAIL sweep_counts: got taken=%0d nottaken=%0d want %0d %0d", taken_cnt, nottaken_cnt, m_taken, m_nottaken);
      end
   endtask

   task automatic test_random();
      bit exp, is_reg;
      int c, f, wen, exf, pc, im, rt, tgt, hold;
      for (int it = 0; it < 200; it++) begin
         is_reg = 1'($urandom_range(0, 1));
         c   = $urandom_range(0, 7);
         f   = $urandom_range(0, 7);
         wen = $urandom_range(0, 7);
         exf = $urandom_range(0, 7);
         pc  = $urandom_range(0, 16'hFFFF) & 16'hFFFE;
         im  = $urandom_range(0, 511);
         rt  = $urandom_range(0, 16'hFFFF);
         exp = ref_taken(c, f, wen, exf);
         tgt = ref_target(is_reg, pc, im, rt);
         drive(is_reg, c, pc, im, rt, f, wen, exf);
         redirect_ready = 1'($urandom_range(0, 1));
         br_valid = 1'b1;
         tick();
         br_valid = 1'b0;
         redirect_ready = 1'b0;
         model_count(exp);
         checks++;
         if (redirect_valid !== exp || (exp && redirect_pc !== tgt[ADDR_W-1:0])) begin
            failures++;
            $display("FAIL random_%0d: got valid=%b pc=%h want %b %h", it, redirect_valid, redirect_pc, exp, tgt[ADDR_W-1:0]);
         end
         if (exp) begin
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
               br_valid = 1'($urandom_range(0, 1));
               tick();
               checks++;
               if (redirect_valid !== 1'b1 || redirect_pc !== tgt[ADDR_W-1:0] || flush !== 1'b0) begin
                  failures++;
                  $display("FAIL random_hold_%0d: got valid=%b pc=%h flush=%b want 1 %h 0", it, redirect_valid, redirect_pc, flush, tgt[ADDR_W-1:0]);
               end
            end
            redirect_ready = 1'b1;
            tick();
            redirect_ready = 1'b0;
            br_valid = 1'b0;
         end
         checks++;
         if (taken_cnt !== m_taken[CNT_W-1:0] || nottaken_cnt !== m_nottaken[CNT_W-1:0]) begin
            failures++;
            $display("FAIL random_cnt_%0d: got taken=%0d nottaken=%0d want %0d %0d", it, taken_cnt, nottaken_cnt, m_taken, m_nottaken);
         end
      end
   endtask

   task automatic test_saturation_and_reset();
      apply_reset();
      drive(0, 0, 16'h0400, 0, 0, 3'b001, 0, 0);
      br_valid = 1'b1;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         tick();
         model_count(0);
      end
      br_valid = 1'b0;
      checks++;
      if (nottaken_cnt !== m_nottaken[CNT_W-1:0] || nottaken_cnt !== 16'hFFFF || taken_cnt !== 16'h0) begin
         failures++;
         $display("FAIL saturation: got nottaken=%h taken=%h want ffff 0000", nottaken_cnt, taken_cnt);
      end
      drive(1, 7, 0, 0, 16'h1234, 0, 0, 0);
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      checks++;
      if (redirect_valid !== 1'b1 || taken_cnt !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset_redirect: got valid=%b taken=%0d want 1 1", redirect_valid, taken_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || taken_cnt !== 16'h0 || nottaken_cnt !== 16'h0) begin
         failures++;
         $display("FAIL async_reset: got valid=%b flush=%b taken=%h nottaken=%h want 0 0 0 0", redirect_valid, flush, taken_cnt, nottaken_cnt);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      checks++;
      if (br_ready !== 1'b1 || redirect_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: got ready=%b valid=%b want 1 0", br_ready, redirect_valid);
      end
   endtask

   initial begin
      test_reset();
      test_eq_basic();
      test_bypass();
      test_backpressure();
      test_wrap();
      test_cond_sweep();
      test_random();
      test_saturation_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
